serial_subtractor: RTL and testbench

SERIAL_SUBTRACTOR -- requirements
Module: serial_subtractor

---
 rtl/serial_subtractor_pkg.sv | 13 +
 rtl/serial_subtractor_fs.sv | 14 +
 rtl/serial_subtractor.sv | 99 +++++++++
 tb/tb_serial_subtractor.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/serial_subtractor_pkg.sv
// Shared types for the bit-serial subtractor.
// State encodings and default operand width.
package serial_subtractor_pkg;

  localparam int N_DEF = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/serial_subtractor_fs.sv
// One-bit full subtractor used by the serial datapath.
// Purely combinational.
module full_subtractor (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic d,
  output logic bout
);

  assign d    = a ^ b ^ bin;
  assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: one bit per cycle, LSB first.
// Result and borrow are published only in the DONE cycle.
module serial_subtractor
  import serial_subtractor_pkg::*;
#(
  parameter int N = N_DEF
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [N-1:0] Aarr,
  input  logic [N-1:0] Barr,
  input  logic         Bi,
  output logic [N-1:0] Diff,
  output logic         Bo,
  output logic         busy,
  output logic         done
);

  localparam int CW = $clog2(N + 1);

  state_t        state;
  state_t        nstate;
  logic [CW-1:0] cnt;
  logic [N-1:0]  a_r;
  logic [N-1:0]  b_r;
  logic [N-1:0]  res;
  logic          br;
  logic          d_bit;
  logic          b_out;
  logic          last;

  assign last = (cnt == CW'(N - 1));

  full_subtractor u_fs (
    .a    (a_r[0]),
    .b    (b_r[0]),
    .bin  (br),
    .d    (d_bit),
    .bout (b_out)
  );

  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= nstate;
  end

  // next-state logic
  always_comb begin
    nstate = state;
    unique case (state)
      IDLE:    if (start) nstate = SHIFT;
      SHIFT:   if (last) nstate = DONE;
      DONE:    nstate = IDLE;
      default: nstate = IDLE;
    endcase
  end

  // operand shift registers, borrow chain and partial result
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
      a_r <= '0;
      b_r <= '0;
      res <= '0;
      br  <= 1'b0;
    end else if (state == IDLE) begin
      if (start) begin
        cnt <= '0;
        a_r <= Aarr;
        b_r <= Barr;
        br  <= Bi;
        res <= '0;
      end
    end else if (state == SHIFT) begin
      cnt <= cnt + 1'b1;
      a_r <= a_r >> 1;
      b_r <= b_r >> 1;
      br  <= b_out;
      res <= (res >> 1) | (N'(d_bit) << (N - 1));
    end
  end

  // publish the full result on entry to DONE only
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      Diff <= '0;
      Bo   <= 1'b0;
    end else if (state == SHIFT && last) begin
      Diff <= (res >> 1) | (N'(d_bit) << (N - 1));
      Bo   <= b_out;
    end
  end

  assign busy = (state != IDLE);
  assign done = (state == DONE);

endmodule

// File: tb/tb_serial_subtractor.sv
// Randomized + directed bench for serial_subtractor.
// Timeline model of the operation checked every cycle.
module tb_serial_subtractor;
  import serial_subtractor_pkg::*;

  localparam int N = N_DEF;

  logic         clk = 1'b0;
  logic         rst_n = 1'b1;
  logic         start = 1'b0;
  logic [N-1:0] A = '0;
  logic [N-1:0] B = '0;
  logic         Bi = 1'b0;
  logic [N-1:0] Diff;
  logic         Bo;
  logic         busy;
  logic         done;

  int vectors = 0;
  int miscompares = 0;
  bit armed = 1'b0;

  serial_subtractor #(.N(N)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .Aarr  (A),
    .Barr  (B),
    .Bi    (Bi),
    .Diff  (Diff),
    .Bo    (Bo),
    .busy  (busy),
    .done  (done)
  );

  always #5 clk = ~clk;

  task automatic chk(string nm, logic [31:0] got, logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, got, exp, $time);
    end
  endtask

  // Model: an accepted op keeps the unit busy for N+1 cycles,
  // the last of which is the done cycle carrying the result.
  int           m_rem = 0;
  int           ma = 0;
  int           mb = 0;
  int           mbi = 0;
  logic [N-1:0] m_diff = '0;
  logic         m_bo = 1'b0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_rem  <= 0;
      m_diff <= '0;
      m_bo   <= 1'b0;
    end else if (m_rem == 0) begin
      if (start) begin
        ma    <= int'(A);
        mb    <= int'(B);
        mbi   <= int'(Bi);
        m_rem <= N + 1;
      end
    end else begin
      m_rem <= m_rem - 1;
      if (m_rem == 2) begin
        m_diff <= N'(ma - mb - mbi);
        m_bo   <= (ma - mb - mbi) < 0;
      end
    end
  end

  // every-cycle comparison against the model
  always @(negedge clk) begin
    if (armed) begin
      chk("busy", 32'(busy), 32'(m_rem > 0));
      chk("done", 32'(done), 32'(m_rem == 1));
      chk("diff", 32'(Diff), 32'(m_diff));
      chk("bo", 32'(Bo), 32'(m_bo));
    end
  end

  task automatic op(input logic [N-1:0] a, input logic [N-1:0] b,
                    input logic bi, input bit poke,
                    output logic [N-1:0] d, output logic bo,
                    output int lat);
    int g;
    g = 0;
    while (busy && g < 50) begin
      @(negedge clk);
      g++;
    end
    start = 1'b1;
    A = a;
    B = b;
    Bi = bi;
    @(posedge clk);
    #1;
    start = 1'b0;
    A = N'($urandom);
    B = N'($urandom);
    Bi = 1'($urandom);
    lat = 0;
    d = '0;
    bo = 1'b0;
    forever begin
      @(negedge clk);
      lat++;
      if (poke && lat == 1) begin
        start = 1'b1;
        A = '0;
      end
      if (poke && lat == 2) start = 1'b0;
      if (done) begin
        d = Diff;
        bo = Bo;
        break;
      end
      if (lat > N + 6) begin
        chk("done_timeout", 32'd0, 32'd1);
        break;
      end
    end
  endtask

  initial begin
    logic [N-1:0] d;
    logic         bo;
    int           lat;
    int           n;
    int           exp;

    #1 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_diff", 32'(Diff), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    armed = 1'b1;
    rst_n = 1'b1;

    op(4'b0001, 4'b0010, 1'b0, 1'b0, d, bo, lat);
    chk("d26_lat", 32'(lat), 32'd5);
    chk("d26_diff", 32'(d), 32'hF);
    chk("d26_bo", 32'(bo), 32'd1);

    op(4'b1111, 4'b1010, 1'b1, 1'b0, d, bo, lat);
    chk("d27a_diff", 32'(d), 32'h4);
    chk("d27a_bo", 32'(bo), 32'd0);
    op(4'b1010, 4'b1100, 1'b1, 1'b0, d, bo, lat);
    chk("d27b_diff", 32'(d), 32'hD);
    chk("d27b_bo", 32'(bo), 32'd1);

    op(4'b0000, 4'b0000, 1'b1, 1'b0, d, bo, lat);
    chk("d28a_diff", 32'(d), 32'hF);
    chk("d28a_bo", 32'(bo), 32'd1);
    op(4'b0000, 4'b0000, 1'b0, 1'b0, d, bo, lat);
    chk("d28b_diff", 32'(d), 32'h0);
    chk("d28b_bo", 32'(bo), 32'd0);

    op(4'b1001, 4'b0011, 1'b0, 1'b1, d, bo, lat);
    chk("d29_diff", 32'(d), 32'h6);
    chk("d29_bo", 32'(bo), 32'd0);
    n = 0;
    repeat (N + 3) begin
      @(negedge clk);
      if (done) n++;
    end
    chk("d29_extra_done", 32'(n), 32'd0);

    // reset in the second SHIFT cycle
    start = 1'b1;
    A = 4'b0111;
    B = 4'b0001;
    Bi = 1'b0;
    @(posedge clk);
    #1 start = 1'b0;
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("d30_diff", 32'(Diff), 32'd0);
    chk("d30_bo", 32'(Bo), 32'd0);
    chk("d30_busy", 32'(busy), 32'd0);
    chk("d30_done", 32'(done), 32'd0);
    n = 0;
    repeat (N + 2) begin
      @(negedge clk);
      if (done) n++;
    end
    chk("d30_no_done", 32'(n), 32'd0);
    rst_n = 1'b1;
    op(4'b0111, 4'b0001, 1'b0, 1'b0, d, bo, lat);
    chk("d30_after_diff", 32'(d), 32'h6);
    chk("d30_after_lat", 32'(lat), 32'(N + 1));

    // start held high: one op per N+2 cycles
    while (busy) @(negedge clk);
    n = 0;
    start = 1'b1;
    A = N'($urandom);
    B = N'($urandom);
    for (int i = 0; i < 3 * (N + 2); i++) begin
      @(negedge clk);
      if (done) n++;
      A = N'($urandom);
      B = N'($urandom);
      Bi = 1'($urandom);
    end
    start = 1'b0;
    chk("tput_dones", 32'(n), 32'd3);

    // exhaustive sweep
    for (int k = 0; k < 512; k++) begin
      op(N'(k >> 5), N'(k >> 1), 1'(k), 1'b0, d, bo, lat);
      exp = (k >> 5) - ((k >> 1) & 15) - (k & 1);
      chk("sweep", {27'd0, bo, d}, 32'(exp) & 32'h1F);
    end

    // random ops with random idle gaps and mid-op pokes
    for (int k = 0; k < 150; k++) begin
      repeat ($urandom_range(0, 3)) @(negedge clk);
      op(N'($urandom), N'($urandom), 1'($urandom),
         1'($urandom), d, bo, lat);
      chk("rand_lat", 32'(lat), 32'(N + 1));
    end

    repeat (3) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
